// File: rtl/luhn_pkg.sv
// luhn_pkg -- shared definitions for the Luhn check-digit generator.
//   state_e     : FSM encoding (IDLE, LOAD, CALC, EMIT, DONE)
//   dbl()       : Luhn doubling of one BCD digit (2d, minus 9 when it exceeds 9)
//   add_mod10() : sum of two 0..9 values, reduced mod 10
package luhn_pkg;

  localparam int BCD_MAX            = 9;
  localparam int DEFAULT_MAX_DIGITS = 19;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic [3:0] dbl(input logic [3:0] d);
    logic [4:0] t;
    t = {d, 1'b0};
    return (t > 5'd9) ? 4'(t - 5'd9) : t[3:0];
  endfunction

  // Both operands are 0..9, so a single conditional subtract is enough.
  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
  endfunction

endpackage

// File: rtl/luhn_digit_buf.sv
// luhn_digit_buf -- MAX_DIGITS x 4-bit payload store.
//   clk                        : clock
//   wr_en, wr_idx, wr_data     : synchronous write port
//   rd_idx -> rd_data          : combinational read port (0 when out of range)
// Storage is deliberately not reset; contents are only read after being written.
module luhn_digit_buf #(
  parameter int MAX_DIGITS = 19,
  parameter int IDX_W      = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [3:0]       rd_data
);

  logic [3:0] mem_q [MAX_DIGITS];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_idx) < MAX_DIGITS)) mem_q[wr_idx] <= wr_data;
  end

  assign rd_data = (32'(rd_idx) < MAX_DIGITS) ? mem_q[rd_idx] : 4'd0;

endmodule

// File: rtl/luhn_check_gen.sv
// luhn_check_gen -- takes a BCD payload MSD-first, computes its Luhn check
// digit and replays payload + check digit on a valid/ready output stream.
//   clk, rst (sync, active-low)
//   go                                   : start request, honoured in IDLE only
//   in_valid/in_digit/in_last/in_ready   : payload input stream
//   out_valid/out_digit/out_last/out_ready : payload + check digit output stream
//   check_digit : registered result, held until the next go
//   busy / done / err : status (done is a 1-cycle pulse, err sticky until go)
//
// Two running sums are kept because the doubling parity is only known once the
// payload length is: sum_e doubles even indices, sum_o doubles odd indices.
// The rightmost payload digit must be doubled, so CALC picks sum_e for an odd
// length and sum_o for an even one.
module luhn_check_gen
  import luhn_pkg::*;
#(
  parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       in_valid,
  input  logic [3:0] in_digit,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_last,
  input  logic       out_ready,
  output logic [3:0] check_digit,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
  logic [3:0]       sum_e_q, sum_e_d;
  logic [3:0]       sum_o_q, sum_o_d;
  logic [3:0]       chk_q, chk_d;
  logic             err_q, err_d;

  logic             wr_en;
  logic [3:0]       rd_data;
  logic [3:0]       sel;

  luhn_digit_buf #(
    .MAX_DIGITS (MAX_DIGITS),
    .IDX_W      (CNT_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (cnt_q),
    .wr_data (in_digit),
    .rd_idx  (rd_idx_q),
    .rd_data (rd_data)
  );

  assign sel = cnt_q[0] ? sum_e_q : sum_o_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_idx_d  = rd_idx_q;
    sum_e_d   = sum_e_q;
    sum_o_d   = sum_o_q;
    chk_d     = chk_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_digit = 4'd0;
    out_last  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          cnt_d    = '0;
          rd_idx_d = '0;
          sum_e_d  = 4'd0;
          sum_o_d  = 4'd0;
          chk_d    = 4'd0;
          err_d    = 1'b0;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_digit > 4'(BCD_MAX)) begin
            // Bad digit is dropped; sums are irrelevant on the error path.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (!cnt_q[0]) begin
              sum_e_d = add_mod10(sum_e_q, dbl(in_digit));
              sum_o_d = add_mod10(sum_o_q, in_digit);
            end else begin
              sum_e_d = add_mod10(sum_e_q, in_digit);
              sum_o_d = add_mod10(sum_o_q, dbl(in_digit));
            end
            if (in_last) begin
              state_d = CALC;
            end else if (cnt_q == CNT_W'(MAX_DIGITS - 2)) begin
              // No room left for the check digit after this one.
              err_d   = 1'b1;
              state_d = DONE;
            end
          end
        end
      end

      CALC: begin
        chk_d    = (sel == 4'd0) ? 4'd0 : 4'(4'd10 - sel);
        rd_idx_d = '0;
        state_d  = EMIT;
      end

      EMIT: begin
        out_valid = 1'b1;
        out_last  = (rd_idx_q == cnt_q);
        out_digit = out_last ? chk_q : rd_data;
        if (out_ready) begin
          if (out_last) state_d = DONE;
          else          rd_idx_d = rd_idx_q + 1'b1;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_idx_q <= '0;
      sum_e_q  <= 4'd0;
      sum_o_q  <= 4'd0;
      chk_q    <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_idx_q <= rd_idx_d;
      sum_e_q  <= sum_e_d;
      sum_o_q  <= sum_o_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign check_digit = chk_q;
  assign err         = err_q;

endmodule

// File: tb/tb_luhn_check_gen.sv
module tb_luhn_check_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       go = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_digit = 4'd0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic [3:0] check_digit;
  logic       busy;
  logic       done;
  logic       err;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  luhn_check_gen dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .in_valid    (in_valid),
    .in_digit    (in_digit),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_digit   (out_digit),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .check_digit (check_digit),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // go pulse; a stray in_valid rides along with go and must not be taken.
  task automatic start();
    @(negedge clk);
    go = 1'b1; in_valid = 1'b1; in_digit = 4'd6; in_last = 1'b0;
    @(negedge clk);
    go = 1'b0; in_valid = 1'b0;
    chk("load_in_ready", in_ready, 1);
    chk("load_busy", busy, 1);
  endtask

  // Drives one digit per cycle; ends on the negedge after the final handshake.
  task automatic load(input int d[$], input bit mark_last);
    foreach (d[i]) begin
      in_valid = 1'b1;
      in_digit = 4'(d[i]);
      in_last  = mark_last && (i == d.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect(input int exp[$], input bit thr, input int lim);
    int k = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [3:0] hd = 4'd0;
    logic hl = 1'b0;
    while (k < lim && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("out_valid_latency", out_valid, 1);
      if (out_valid) begin
        if (stalled) begin
          chk("stall_digit", out_digit, hd);
          chk("stall_last", out_last, hl);
        end
        out_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          chk($sformatf("digit%0d", k), out_digit, exp[k]);
          chk($sformatf("last%0d", k), out_last, (k == exp.size() - 1));
          k++;
          stalled = 0;
        end else begin
          stalled = 1; hd = out_digit; hl = out_last;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    if (k < lim) chk("collect_timeout", k, lim);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic post_ok(input int exp_chk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_check", check_digit, exp_chk);
    chk("done_err", err, 0);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_check_hold", check_digit, exp_chk);
  endtask

  task automatic post_err();
    chk("err_done", done, 1);
    chk("err_flag", err, 1);
    chk("err_out_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_no_out", out_valid, 0);
      chk("err_sticky", err, 1);
      chk("err_done_clr", done, 0);
    end
  endtask

  initial begin
    int p[$];
    int s[$];

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_check", check_digit, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    // 7992739871 -> 3
    p = '{7,9,9,2,7,3,9,8,7,1};
    s = '{7,9,9,2,7,3,9,8,7,1,3};
    start(); load(p, 1);
    chk("calc_no_out", out_valid, 0);
    collect(s, 0, s.size()); post_ok(3);

    // single digits
    start(); p = '{5}; s = '{5,9}; load(p, 1);
    collect(s, 0, 2); post_ok(9);
    start(); p = '{0}; s = '{0,0}; load(p, 1);
    collect(s, 0, 2); post_ok(0);

    // 15 digits with random backpressure -> 7
    p = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6};
    s = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6,7};
    start(); load(p, 1);
    collect(s, 1, s.size()); post_ok(7);

    // bad digit
    start(); p = '{1,2,10}; load(p, 1);
    post_err();
    // recovery: err clears on go
    start();
    chk("err_clear_on_go", err, 0);
    p = '{1,8}; s = '{1,8,2}; load(p, 1);
    collect(s, 0, 3); post_ok(2);

    // overflow: 18 digits without in_last
    p.delete();
    for (int i = 0; i < 18; i++) p.push_back(i % 10);
    start(); load(p, 0);
    post_err();

    // reset mid-EMIT
    p = '{7,9,9,2,7,3,9,8,7,1};
    s = '{7,9,9,2,7,3,9,8,7,1,3};
    start(); load(p, 1);
    collect(s, 0, 3);
    chk("mid_emit_valid", out_valid, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_digit", out_digit, 0);
    chk("mrst_out_last", out_last, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    chk("mrst_check", check_digit, 0);
    chk("mrst_in_ready", in_ready, 0);
    rst = 1'b1;
    start(); p = '{5}; s = '{5,9}; load(p, 1);
    collect(s, 0, 2); post_ok(9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
